// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register controller.
// Holds the controller state enumeration, command-byte field positions
// and the default identification value returned from the top register.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // Command byte layout: bit7 selects read (1) or write (0); bits[2:0]
  // carry the start address; bits[6:3] are don't-care.
  localparam int RW_BIT        = 7;
  localparam int ADDR_LSB      = 0;
  localparam int CMD_ADDR_BITS = 3;

  localparam logic [7:0] DEFAULT_ID_VALUE = 8'hA5;

endpackage

// File: rtl/spi_regfile.sv
// Register file for the SPI controller: N_REGS x 8-bit, one write port,
// one asynchronous read port. The top address reads back ID_VALUE.
// Ports: clk, rst_n, we/waddr/wdata (write), raddr/rdata (comb read).
module spi_regfile #(
  parameter int          N_REGS   = 8,
  parameter int          AW       = 3,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam logic [AW-1:0] TOP_ADDR = AW'(N_REGS - 1);

  logic [7:0] mem [N_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The top slot is a read-only identifier; its storage is never exposed.
  assign rdata = (raddr == TOP_ADDR) ? ID_VALUE : mem[raddr];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Byte-level SPI register controller: decodes a command byte, then bursts
// writes or reads over a small register file with address wrap.
// Ports: clk/rst_n, cs_n + rx_byte/rx_valid in, tx_byte/tx_load, led, busy, err out.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         N_REGS   = 8,
  parameter logic [7:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] led,
  output logic       busy,
  output logic       err
);

  localparam int            AW       = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [AW-1:0] TOP_ADDR = AW'(N_REGS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = '0;

  state_t state, state_nxt;

  logic          cs_n_d;
  logic          cs_fall;
  logic [AW-1:0] addr, addr_nxt, addr_inc, cmd_addr, rd_addr;
  logic [CMD_ADDR_BITS-1:0] cmd_field;
  logic [7:0]    rd_data;
  logic [7:0]    tx_nxt;
  logic          we;
  logic          err_set, err_clr;
  logic          tx_due, tx_zero;
  logic          tx_pend;

  // cs_n_d resets low so that a chip select already held low when reset
  // is released is not mistaken for a fresh falling edge.
  assign cs_fall   = cs_n_d & ~cs_n;
  assign addr_inc  = (addr == TOP_ADDR) ? ZERO_ADDR : addr + 1'b1;
  assign cmd_field = rx_byte[ADDR_LSB +: CMD_ADDR_BITS];
  assign cmd_addr  = AW'(32'(cmd_field) % N_REGS);
  assign busy      = (state != ST_IDLE);

  spi_regfile #(
    .N_REGS  (N_REGS),
    .AW      (AW),
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(addr),
    .wdata(rx_byte),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus per-cycle control. A byte arriving together with
  // cs_n high is still handled before the state drops back to IDLE.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rd_addr   = addr_inc;
    we        = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    tx_due    = 1'b0;
    tx_zero   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          err_set = 1'b1;
        end
        if (cs_fall) begin
          state_nxt = ST_CMD;
          tx_due    = 1'b1;
          tx_zero   = 1'b1;
        end
      end

      ST_CMD: begin
        if (rx_valid) begin
          addr_nxt = cmd_addr;
          rd_addr  = cmd_addr;
          if (rx_byte[RW_BIT]) begin
            state_nxt = ST_RDATA;
            tx_due    = ~cs_n;
          end else begin
            state_nxt = ST_WDATA;
          end
        end
        if (cs_n) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_WDATA: begin
        if (rx_valid) begin
          addr_nxt = addr_inc;
          if (addr == TOP_ADDR) begin
            err_set = 1'b1;
          end else begin
            we = 1'b1;
            if (addr == ZERO_ADDR) begin
              err_clr = 1'b1;
            end
          end
        end
        if (cs_n) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_RDATA: begin
        if (rx_valid) begin
          addr_nxt = addr_inc;
          tx_due   = ~cs_n;
        end
        if (cs_n) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    tx_nxt = tx_zero ? 8'h00 : rd_data;
  end

  // Datapath registers. A load that falls due while tx_load is already
  // high is deferred by one cycle so tx_load never stays high twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_d  <= 1'b0;
      addr    <= '0;
      led     <= 8'h00;
      err     <= 1'b0;
      tx_byte <= 8'h00;
      tx_load <= 1'b0;
      tx_pend <= 1'b0;
    end else begin
      cs_n_d <= cs_n;
      addr   <= addr_nxt;

      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      if (we && (addr == ZERO_ADDR)) begin
        led <= rx_byte;
      end

      if (tx_due) begin
        tx_byte <= tx_nxt;
        tx_load <= ~tx_load;
        tx_pend <= tx_load;
      end else begin
        tx_load <= tx_pend;
        tx_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] led;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  logic       prev_load = 1'b0;
  int         load_viol = 0;

  spi_reg_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_n    (cs_n),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .tx_byte (tx_byte),
    .tx_load (tx_load),
    .led     (led),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record every byte offered to the SPI core; flag back-to-back loads.
  always @(negedge clk) begin
    if (tx_load) begin
      txq.push_back(tx_byte);
      if (prev_load) load_viol++;
    end
    prev_load = tx_load;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input int n,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    logic [7:0] o;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_count"}, 8'(txq.size()), 8'(n));
    for (int i = 0; i < n; i++) begin
      o = (i < txq.size()) ? txq[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), o, e[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    txq.delete();
    cs_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_led", led, 8'h00);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_load", {7'd0, tx_load}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_err", {7'd0, err}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Write burst: regs[0]=3C, regs[1]=11
    cs_low();
    chk("wr_busy", {7'd0, busy}, 8'h01);
    send(8'h00);
    chk("wr_led_before", led, 8'h00);
    send(8'h3C);
    chk("wr_led_after", led, 8'h3C);
    send(8'h11);
    cs_high();
    chk("wr_idle_busy", {7'd0, busy}, 8'h00);
    chk_tx("wr_tx", 1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Read back regs 0 and 1
    cs_low();
    send(8'h80);
    send(8'h00);
    cs_high();
    chk_tx("rd01", 3, 8'h00, 8'h3C, 8'h11, 8'h00);

    // Preload regs[6]=77, then read with wrap 6 -> 7 -> 0
    cs_low();
    send(8'h06);
    send(8'h77);
    cs_high();
    cs_low();
    send(8'h86);
    send(8'hEE);
    send(8'hDD);
    cs_high();
    chk_tx("rd_wrap", 4, 8'h00, 8'h77, 8'hA5, 8'h3C);

    // ID protection: write FF to reg7
    cs_low();
    send(8'h07);
    send(8'hFF);
    cs_high();
    chk("id_err", {7'd0, err}, 8'h01);
    cs_low();
    send(8'h87);
    cs_high();
    chk_tx("id_rd", 2, 8'h00, 8'hA5, 8'h00, 8'h00);

    // Writing reg0 clears the error flag
    cs_low();
    send(8'h78);  // bits[6:3] ignored -> address 0
    send(8'h81);
    cs_high();
    chk("clr_err", {7'd0, err}, 8'h00);
    chk("clr_led", led, 8'h81);

    // Abort after command byte 02
    cs_low();
    send(8'h02);
    cs_high();
    chk("abort_busy", {7'd0, busy}, 8'h00);
    cs_low();
    send(8'h82);
    cs_high();
    chk_tx("abort_rd", 2, 8'h00, 8'h00, 8'h00, 8'h00);

    // Last data byte coincides with cs_n rising
    cs_low();
    send(8'h03);
    @(negedge clk);
    rx_byte  = 8'h5A;
    rx_valid = 1'b1;
    cs_n     = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("simul_busy", {7'd0, busy}, 8'h00);
    cs_low();
    send(8'h83);
    cs_high();
    chk_tx("simul_rd", 2, 8'h00, 8'h5A, 8'h00, 8'h00);

    // Reset mid write burst, cs_n held low across reset
    cs_low();
    send(8'h04);
    send(8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", led, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    chk("mid_rst_tx_load", {7'd0, tx_load}, 8'h00);
    chk("mid_rst_tx_byte", tx_byte, 8'h00);
    chk("mid_rst_err", {7'd0, err}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h34);
    chk("post_rst_busy", {7'd0, busy}, 8'h00);
    chk("post_rst_err", {7'd0, err}, 8'h01);
    send(8'h56);
    chk("post_rst_led", led, 8'h00);
    cs_high();
    cs_low();
    send(8'h84);
    send(8'h00);
    cs_high();
    chk_tx("post_rst_rd", 3, 8'h00, 8'h00, 8'h00, 8'h00);

    // tx_load must never be high on two consecutive cycles
    chk("tx_load_spacing", 8'(load_viol), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
